// File: rtl/adder_arb_pkg.sv
// Shared defaults, ID width derivation and reset values for the adder_arb sequencer.
package adder_arb_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int NUM_REQ_DEF = 4;

  localparam int   PTR_RST       = 0;
  localparam int   RSP_ID_RST    = 0;
  localparam int   RSP_SUM_RST   = 0;
  localparam logic RSP_VALID_RST = 1'b0;
  localparam logic RSP_CARRY_RST = 1'b0;

  function automatic int calc_id_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to bit 0.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  logic [NUM_REQ-1:0] upper;
  logic [NUM_REQ-1:0] sel;

  // Requests at or above ptr win first; otherwise fall back to the lowest set bit overall.
  always_comb begin
    upper = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      upper[i] = (i >= int'(ptr));
    end
    sel = (|(req & upper)) ? (req & upper) : req;
  end

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && sel[i]) begin
        any    = 1'b1;
        gnt[i] = 1'b1;
        idx    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/adder_arb.sv
// Round-robin sequencer sharing one WIDTH-bit adder among NUM_REQ requesters.
// Define ADDER_ARB_CARRY_EN to add the registered rsp_carry output.
module adder_arb
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int ID_W    = calc_id_w(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_sum
`ifdef ADDER_ARB_CARRY_EN
  ,
  output logic                     rsp_carry
`endif
);

  logic               vld_p1;
  logic [ID_W-1:0]    id_p1;
  logic [WIDTH-1:0]   sum_p1;
  logic [ID_W-1:0]    ptr_p1;

  logic               free_p0;
  logic [NUM_REQ-1:0] req_p0;
  logic [NUM_REQ-1:0] gnt_p0;
  logic [ID_W-1:0]    idx_p0;
  logic               any_p0;
  logic [WIDTH-1:0]   a_p0;
  logic [WIDTH-1:0]   b_p0;
  logic [WIDTH-1:0]   sum_p0;
  logic [ID_W-1:0]    ptr_nxt_p0;

  // Stage p0: arbitration, operand mux and add.
  assign free_p0 = !vld_p1 || rsp_ready;
  assign req_p0  = (free_p0 && !clear) ? req_valid : '0;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req (req_p0),
    .ptr (ptr_p1),
    .gnt (gnt_p0),
    .idx (idx_p0),
    .any (any_p0)
  );

  assign req_ready = gnt_p0;

  always_comb begin
    a_p0 = '0;
    b_p0 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_p0[i]) begin
        a_p0 = req_a[i*WIDTH +: WIDTH];
        b_p0 = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef ADDER_ARB_CARRY_EN
  logic [WIDTH:0] full_p0;
  logic           carry_p0;
  logic           carry_p1;
  assign full_p0  = {1'b0, a_p0} + {1'b0, b_p0};
  assign sum_p0   = full_p0[WIDTH-1:0];
  assign carry_p0 = full_p0[WIDTH];
`else
  assign sum_p0 = a_p0 + b_p0;
`endif

  assign ptr_nxt_p0 = (idx_p0 == ID_W'(NUM_REQ - 1)) ? '0 : idx_p0 + ID_W'(1);

  // Stage p1: result register and priority pointer.
  always_ff @(posedge clk) begin
    if (clear) begin
      vld_p1 <= RSP_VALID_RST;
      id_p1  <= ID_W'(RSP_ID_RST);
      sum_p1 <= WIDTH'(RSP_SUM_RST);
      ptr_p1 <= ID_W'(PTR_RST);
`ifdef ADDER_ARB_CARRY_EN
      carry_p1 <= RSP_CARRY_RST;
`endif
    end else if (any_p0) begin
      vld_p1 <= 1'b1;
      id_p1  <= idx_p0;
      sum_p1 <= sum_p0;
      ptr_p1 <= ptr_nxt_p0;
`ifdef ADDER_ARB_CARRY_EN
      carry_p1 <= carry_p0;
`endif
    end else if (rsp_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign rsp_valid = vld_p1;
  assign rsp_id    = id_p1;
  assign rsp_sum   = sum_p1;
`ifdef ADDER_ARB_CARRY_EN
  assign rsp_carry = carry_p1;
`endif

endmodule

// File: tb/tb_adder_arb.sv
// Scoreboard bench for adder_arb: grants and results checked against a behavioural model.
module tb_adder_arb;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           clear;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_sum;
`ifdef ADDER_ARB_CARRY_EN
  logic           rsp_carry;
`endif

  always #5 clk = ~clk;

  adder_arb #(.NUM_REQ(N), .WIDTH(W), .ID_W(2)) dut (
    .clk       (clk),
    .clear     (clear),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum)
`ifdef ADDER_ARB_CARRY_EN
    ,
    .rsp_carry (rsp_carry)
`endif
  );

  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] sum;
  } rsp_t;

  rsp_t sb[$];
  int   m_ptr;
  bit   m_vld;
  int   vectors;
  int   miscompares;

  function automatic logic [N-1:0] exp_grant();
    logic [N-1:0] g;
    g = '0;
    if (clear || (m_vld && !rsp_ready)) return g;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_valid[i]) begin
        g[i] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  function automatic logic [W-1:0] held_sum();
    return (sb.size() > 0) ? sb[0].sum : '0;
  endfunction

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  // Advances the model by one clock edge, then moves to the next falling edge.
  task automatic advance();
    logic [N-1:0] g;
    g = exp_grant();
    if (m_vld && rsp_ready) void'(sb.pop_front());
    if (g != '0) begin
      for (int i = 0; i < N; i++) begin
        if (g[i]) begin
          sb.push_back('{id: 2'(i), sum: req_a[i*W +: W] + req_b[i*W +: W]});
          m_ptr = (i + 1) % N;
        end
      end
      m_vld = 1'b1;
    end else if (rsp_ready) begin
      m_vld = 1'b0;
    end
    if (clear) begin
      sb.delete();
      m_vld = 1'b0;
      m_ptr = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear = 1'b1; req_valid = '1; rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_op(i, 32'h100 * (i + 1), 32'h7 + i);
    m_ptr = 0; m_vld = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); @(negedge clk); #1;
      vectors++;
      if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_sum !== '0) begin
        miscompares++;
        $display("FAIL reset_c%0d: got ready=%b vld=%b id=%0d sum=%h, need all zero",
                 c, req_ready, rsp_valid, rsp_id, rsp_sum);
      end
    end
    clear = 1'b0; #1;
    vectors++;
    if (req_ready !== 4'b0001 || req_ready !== exp_grant()) begin
      miscompares++;
      $display("FAIL reset_first_grant: got %b, need 0001", req_ready);
    end
    advance(); #1;
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 32'h107) begin
      miscompares++;
      $display("FAIL reset_first_rsp: got vld=%b id=%0d sum=%h, need 1/0/00000107",
               rsp_valid, rsp_id, rsp_sum);
    end
  endtask

  task automatic test_single();
    req_valid = 4'b0100; rsp_ready = 1'b1;
    set_op(2, 32'h0, 32'h4);
    for (int k = 0; k < 6; k++) begin
      #1;
      vectors++;
      if (req_ready !== 4'b0100 || req_ready !== exp_grant()) begin
        miscompares++;
        $display("FAIL single_grant%0d: got %b, need 0100", k, req_ready);
      end
      if (k > 0) begin
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 32'd4) begin
          miscompares++;
          $display("FAIL single_rsp%0d: got vld=%b id=%0d sum=%h, need 1/2/00000004",
                   k, rsp_valid, rsp_id, rsp_sum);
        end
      end
      advance();
    end
    req_valid = '0;
    advance();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] order [5];
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;
    clear = 1'b1; advance(); clear = 1'b0;
    req_valid = '1; rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_op(i, $urandom, $urandom);
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors++;
      if (req_ready !== order[k]) begin
        miscompares++;
        $display("FAIL rr_grant%0d: got %b, need %b", k, req_ready, order[k]);
      end
      if (k > 0) begin
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'((k - 1) % N) || rsp_sum !== held_sum()) begin
          miscompares++;
          $display("FAIL rr_rsp%0d: got vld=%b id=%0d sum=%h, need 1/%0d/%h",
                   k, rsp_valid, rsp_id, rsp_sum, (k - 1) % N, held_sum());
        end
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    req_valid = 4'b1010; rsp_ready = 1'b1; #1;
    vectors++;
    if (req_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL bp_first_grant: got %b, need 0010", req_ready);
    end
    advance();
    rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      vectors++;
      if (req_ready !== '0 || rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== held_sum()) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got ready=%b vld=%b id=%0d sum=%h, need 0000/1/1/%h",
                 c, req_ready, rsp_valid, rsp_id, rsp_sum, held_sum());
      end
      advance();
    end
    rsp_ready = 1'b1; #1;
    vectors++;
    if (req_ready !== 4'b1000 || rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin
      miscompares++;
      $display("FAIL bp_release: got ready=%b vld=%b id=%0d, need 1000/1/1",
               req_ready, rsp_valid, rsp_id);
    end
    advance(); #1;
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_sum !== held_sum()) begin
      miscompares++;
      $display("FAIL bp_next_rsp: got vld=%b id=%0d sum=%h, need 1/3/%h",
               rsp_valid, rsp_id, rsp_sum, held_sum());
    end
    req_valid = '0;
    advance();
  endtask

  task automatic test_overflow();
    req_valid = 4'b0001; rsp_ready = 1'b1;
    set_op(0, 32'hFFFF_FFFF, 32'h0000_0002); #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL ovf_grant: got %b, need 0001", req_ready);
    end
    advance(); #1;
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 32'h0000_0001) begin
      miscompares++;
      $display("FAIL ovf_sum: got vld=%b id=%0d sum=%h, need 1/0/00000001",
               rsp_valid, rsp_id, rsp_sum);
    end
`ifdef ADDER_ARB_CARRY_EN
    vectors++;
    if (rsp_carry !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_carry: got %b, need 1", rsp_carry);
    end
`endif
    req_valid = '0;
    advance();
  endtask

  task automatic test_clear_mid();
    req_valid = 4'b0100; rsp_ready = 1'b0;
    set_op(2, 32'h0000_1234, 32'h0000_0010); #1;
    vectors++;
    if (req_ready !== exp_grant() || req_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL clr_grant: got %b, need 0100", req_ready);
    end
    advance(); #1;
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 32'h0000_1244) begin
      miscompares++;
      $display("FAIL clr_pending: got vld=%b id=%0d sum=%h, need 1/2/00001244",
               rsp_valid, rsp_id, rsp_sum);
    end
    clear = 1'b1; #1;
    vectors++;
    if (req_ready !== '0) begin
      miscompares++;
      $display("FAIL clr_ready: got %b, need 0000", req_ready);
    end
    advance();
    clear = 1'b0; req_valid = '0; #1;
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_sum !== '0) begin
      miscompares++;
      $display("FAIL clr_outputs: got vld=%b id=%0d sum=%h, need 0/0/00000000",
               rsp_valid, rsp_id, rsp_sum);
    end
    req_valid = '1; rsp_ready = 1'b1; #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL clr_ptr: got %b, need 0001", req_ready);
    end
    advance(); #1;
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== held_sum()) begin
      miscompares++;
      $display("FAIL clr_after_rsp: got vld=%b id=%0d sum=%h, need 1/0/%h",
               rsp_valid, rsp_id, rsp_sum, held_sum());
    end
    req_valid = '0;
    advance();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 60; c++) begin
      req_valid = 4'($urandom);
      rsp_ready = ($urandom % 4) != 0;
      for (int i = 0; i < N; i++) set_op(i, $urandom, $urandom);
      #1;
      vectors++;
      if (req_ready !== exp_grant()) begin
        miscompares++;
        $display("FAIL b2b_grant%0d: got %b, need %b", c, req_ready, exp_grant());
      end
      vectors++;
      if (m_vld) begin
        if (rsp_valid !== 1'b1 || rsp_id !== sb[0].id || rsp_sum !== sb[0].sum) begin
          miscompares++;
          $display("FAIL b2b_rsp%0d: got vld=%b id=%0d sum=%h, need 1/%0d/%h",
                   c, rsp_valid, rsp_id, rsp_sum, sb[0].id, sb[0].sum);
        end
      end else if (rsp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_idle%0d: got vld=%b, need 0", c, rsp_valid);
      end
      advance();
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    clear = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_clear_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adder_arb.md
# adder_arb

Round-robin arbiter and sequencer that shares one 32-bit adder between up to NUM_REQ requesters (PC increment, branch target, load/store address). Accepts one add operation per cycle from the winning requester, registers the sum with the winner's ID, and holds it until the consumer takes it. It sits between the pipeline stages that need additions and the single adder instance, replacing per-stage adders.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (1..8)
- WIDTH, 32, operand/sum width
- ID_W, 2, width of rsp_id; must equal max(1, ceil(log2(NUM_REQ)))

Ports:
- clk  input  1  master clock, all state on rising edge
- clear  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester operation request
- req_a  input  NUM_REQ*WIDTH  operand a, requester i at [i*WIDTH +: WIDTH]
- req_b  input  NUM_REQ*WIDTH  operand b, same packing
- req_ready  output  NUM_REQ  one-hot grant; operation accepted when req_valid[i] && req_ready[i]
- rsp_valid  output  1  registered result available
- rsp_ready  input  1  consumer takes the result this cycle
- rsp_id  output  ID_W  index of requester that owns rsp_sum
- rsp_sum  output  WIDTH  (a + b) mod 2^WIDTH

## Operation
- out_free = !rsp_valid || rsp_ready.
- Arbitration (combinational): if out_free and any req_valid is set, the winner is the first set bit scanning from ptr upward, wrapping at NUM_REQ-1 → 0. req_ready is one-hot on the winner; all other bits are 0. req_ready = 0 when !out_free, when no request is pending, or while clear is high.
- Accept (registered): rsp_sum <= a_w + b_w (carry discarded), rsp_id <= w, rsp_valid <= 1, ptr <= (w+1) mod NUM_REQ.
- No accept and rsp_ready: rsp_valid <= 0; rsp_sum and rsp_id keep their last value.
- !out_free: rsp_valid, rsp_id, rsp_sum and ptr are held stable until rsp_ready.
- ptr changes only on accept. An idle requester does not move priority.
- Fairness: a requester holding req_valid is granted within NUM_REQ accepts.
- Requesters must hold valid and operands stable until granted. Dropping valid before grant is legal and withdraws the request.
- NUM_REQ=1: ptr is constant 0 and the winner is always requester 0.
- Reset: while clear is high at a rising edge, rsp_valid=0, rsp_id=0, rsp_sum=0, ptr=0. Any held result is discarded. A request presented in the same cycle as clear is not accepted.

## Timing
- Latency: accept in cycle N → rsp_valid/rsp_sum visible after edge N+1.
- Throughput: 1 operation/cycle while rsp_ready stays high (back-to-back drain and accept in the same cycle).
- The critical path is operand mux → WIDTH-bit add → register. It must close at 10 ns clock period with the 250-unit adder delay budget.
- req_ready depends combinationally on req_valid, rsp_valid and rsp_ready. Requesters must not feed req_ready back into req_valid in the same cycle.

## Configuration
- ADDER_ARB_CARRY_EN defined: adds output rsp_carry (1 bit), the carry-out of the accepted add. It is registered alongside rsp_sum, resets to 0 and is held with rsp_sum.
- Not defined: the port is absent and the carry is discarded.

## Structure
- Package adder_arb_pkg: WIDTH default (32), NUM_REQ default (4), ID_W derivation function, and reset constants for ptr and rsp fields.
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, binary index, any.
- The add, the output register and the ptr update stay in adder_arb.

## Test plan
- Reset: hold clear 3 cycles with all req_valid=1 → req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0 throughout. First grant after release goes to requester 0.
- Single requester: req 2 issues a=0x00000000, b=0x00000004 every cycle, rsp_ready=1 → one result/cycle, rsp_id=2, rsp_sum=4 one cycle after each accept.
- All four request continuously, rsp_ready=1 → grant order 0,1,2,3,0 (wrap-around). rsp_id follows one cycle later.
- Backpressure: result pending, rsp_ready=0 for 5 cycles with req 1 and 3 valid → req_ready=0, outputs stable. On rsp_ready=1, drain and next grant occur in the same cycle.
- Overflow: a=0xFFFFFFFF, b=0x00000002 → rsp_sum=0x00000001. With ADDER_ARB_CARRY_EN, rsp_carry=1.
- Clear mid-operation: assert clear while rsp_valid=1 and rsp_ready=0 → rsp_valid=0 next edge. The result is lost and ptr resets to 0.
